// File: rtl/instruction_encoder_if.sv
// Handshake and field bundle between a producer of decoded fields and the
// RV32I instruction encoder, plus the encoder's status outputs.
interface instruction_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [31:0] addr;
    logic        illegal_fmt;
    logic [15:0] count;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, instruction, addr, illegal_fmt, count
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, instruction, addr, illegal_fmt, count
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs RV32I field bundles into instruction words, stamps each with a byte
// address and buffers them in a 2-entry FIFO towards the consumer.
module instruction_encoder (
    input  logic                  clk,
    input  logic                  reset,
    instruction_encoder_if.slave  bus
);
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    function automatic logic fmt_legal(input logic [2:0] fmt);
        return (fmt < 3'd6);
    endfunction

    function automatic logic [31:0] pack_word(
        input logic [2:0]  fmt,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (fmt)
            FMT_R:   w = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   w = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   w = {imm[31:12], rd, opcode};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    logic [31:0] word_mem_r [0:1];
    logic [31:0] addr_mem_r [0:1];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  occ_r;
    logic [31:0] addr_cnt_r;
    logic [15:0] count_r;
    logic        illegal_r;

    logic        full_s;
    logic        empty_s;
    logic        in_fire_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] word_s;

    // Handshake decode; illegal formats are accepted but never pushed.
    always_comb begin
        full_s    = (occ_r == 2'd2);
        empty_s   = (occ_r == 2'd0);
        in_fire_s = 1'b0;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        word_s    = pack_word(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2,
                              bus.funct3, bus.funct7, bus.imm);
        if (!reset) begin
            in_fire_s = bus.in_valid && !full_s;
            push_s    = in_fire_s && fmt_legal(bus.fmt);
            pop_s     = !empty_s && bus.out_ready;
        end else begin
            in_fire_s = 1'b0;
        end
    end

    assign bus.in_ready    = !full_s && !reset;
    assign bus.out_valid   = !empty_s;
    assign bus.instruction = empty_s ? 32'd0 : word_mem_r[rd_ptr_r];
    assign bus.addr        = empty_s ? 32'd0 : addr_mem_r[rd_ptr_r];
    assign bus.count       = count_r;
    assign bus.illegal_fmt = illegal_r;

    // FIFO storage: the write slot is captured with its stamped address.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_mem_r[0] <= 32'd0;
            word_mem_r[1] <= 32'd0;
            addr_mem_r[0] <= 32'd0;
            addr_mem_r[1] <= 32'd0;
        end else if (push_s) begin
            word_mem_r[wr_ptr_r] <= word_s;
            addr_mem_r[wr_ptr_r] <= addr_cnt_r;
        end
    end

    // Pointers, occupancy, address stamp, delivered count and illegal pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            occ_r      <= 2'd0;
            addr_cnt_r <= 32'd0;
            count_r    <= 16'd0;
            illegal_r  <= 1'b0;
        end else begin
            illegal_r <= in_fire_s && !fmt_legal(bus.fmt);
            if (push_s) begin
                wr_ptr_r   <= ~wr_ptr_r;
                addr_cnt_r <= addr_cnt_r + 32'd4;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
                if (count_r != 16'hFFFF) begin
                    count_r <= count_r + 16'd1;
                end
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a queue-based reference of the encoder's behaviour.
module tb_instruction_encoder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_encoder_if bus ();
    instruction_encoder dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] a;
    } ent_t;

    int          total = 0;
    int          bad   = 0;
    ent_t        q[$];
    logic [31:0] m_addr;
    int          m_count;
    logic        m_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] bitv(input logic [31:0] v, input int n);
        return (v >> n) & 32'd1;
    endfunction

    // Reference encoding built from field weights rather than concatenation.
    function automatic logic [31:0] ref_word(input logic [31:0] f, op, rd, rs1, rs2, f3, f7, imm);
        logic [31:0] r;
        r = op + f3 * 32'd4096;
        case (f)
            32'd0: r = r + f7 * 32'h0200_0000 + rs2 * 32'h0010_0000 + rs1 * 32'h8000 + rd * 32'd128;
            32'd1: r = r + (imm % 32'd4096) * 32'h0010_0000 + rs1 * 32'h8000 + rd * 32'd128;
            32'd2: r = r + ((imm / 32'd32) % 32'd128) * 32'h0200_0000 + rs2 * 32'h0010_0000
                         + rs1 * 32'h8000 + (imm % 32'd32) * 32'd128;
            32'd3: r = r + bitv(imm, 12) * 32'h8000_0000 + ((imm / 32'd32) % 32'd64) * 32'h0200_0000
                         + rs2 * 32'h0010_0000 + rs1 * 32'h8000
                         + ((imm / 32'd2) % 32'd16) * 32'd256 + bitv(imm, 11) * 32'd128;
            32'd4: r = op + (imm / 32'd4096) * 32'd4096 + rd * 32'd128;
            32'd5: r = op + bitv(imm, 20) * 32'h8000_0000 + ((imm / 32'd2) % 32'd1024) * 32'h0020_0000
                         + bitv(imm, 11) * 32'h0010_0000 + ((imm / 32'd4096) % 32'd256) * 32'd4096
                         + rd * 32'd128;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // One clock: compare outputs mid-cycle, advance the model, step past the edge.
    task automatic cycle();
        ent_t        e;
        logic        exp_rdy;
        logic        ifire;
        logic        ofire;
        logic [31:0] exp_w;
        logic [31:0] exp_a;
        @(negedge clk);
        exp_rdy = !reset && (q.size() < 2);
        if (q.size() > 0) begin
            exp_w = q[0].w;
            exp_a = q[0].a;
        end else begin
            exp_w = 32'd0;
            exp_a = 32'd0;
        end
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        check("out_valid", {31'd0, bus.out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
        check("instruction", bus.instruction, exp_w);
        check("addr", bus.addr, exp_a);
        check("count", {16'd0, bus.count}, m_count);
        check("illegal_fmt", {31'd0, bus.illegal_fmt}, {31'd0, m_ill});
        if (reset) begin
            q.delete();
            m_addr  = 32'd0;
            m_count = 0;
            m_ill   = 1'b0;
        end else begin
            ifire = bus.in_valid && exp_rdy;
            ofire = (q.size() > 0) && bus.out_ready;
            if (ofire) begin
                q.delete(0);
                if (m_count < 65535) m_count++;
            end
            m_ill = ifire && (bus.fmt >= 3'd6);
            if (ifire && bus.fmt < 3'd6) begin
                e.w = ref_word({29'd0, bus.fmt}, {25'd0, bus.opcode}, {27'd0, bus.rd},
                               {27'd0, bus.rs1}, {27'd0, bus.rs2}, {29'd0, bus.funct3},
                               {25'd0, bus.funct7}, bus.imm);
                e.a = m_addr;
                q.push_back(e);
                m_addr = m_addr + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        bus.in_valid = 1'b1;
        bus.fmt      = f;
        bus.opcode   = op;
        bus.rd       = rd;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.imm      = imm;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic push_r();
        drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        idle();
        q.delete();
        m_addr  = 32'd0;
        m_count = 0;
        m_ill   = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;

        // Single R-format word with immediate delivery.
        bus.out_ready = 1'b1;
        push_r();
        cycle();
        idle();
        check("r_word", bus.instruction, 32'h002081B3);
        check("r_addr", bus.addr, 32'd0);
        cycle();
        check("r_count", {16'd0, bus.count}, 32'd1);

        // Back-to-back ADDI, SW, JAL.
        do_reset();
        bus.out_ready = 1'b1;
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        cycle();
        check("addi_word", bus.instruction, 32'hFFF00093);
        check("addi_addr", bus.addr, 32'd0);
        drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        cycle();
        check("sw_word", bus.instruction, 32'h0020A423);
        check("sw_addr", bus.addr, 32'd4);
        drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        cycle();
        check("jal_word", bus.instruction, 32'h008000EF);
        check("jal_addr", bus.addr, 32'd8);
        idle();
        cycle();

        // Backpressure: two words held, then drained in order.
        do_reset();
        bus.out_ready = 1'b0;
        push_r();
        cycle();
        drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        cycle();
        idle();
        for (int i = 0; i < 10; i++) begin
            check("bp_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_word", bus.instruction, 32'h002081B3);
            check("bp_addr", bus.addr, 32'd0);
            cycle();
        end
        bus.out_ready = 1'b1;
        cycle();
        check("bp_second_addr", bus.addr, 32'd4);
        cycle();
        check("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Illegal format is consumed and flagged, address not advanced.
        do_reset();
        bus.out_ready = 1'b0;
        drive(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        cycle();
        check("ill_pulse", {31'd0, bus.illegal_fmt}, 32'd1);
        check("ill_not_queued", {31'd0, bus.out_valid}, 32'd0);
        push_r();
        cycle();
        idle();
        check("ill_pulse_end", {31'd0, bus.illegal_fmt}, 32'd0);
        check("ill_next_addr", bus.addr, 32'd0);
        cycle();

        // Reset with two words buffered and five delivered.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_r();
            cycle();
        end
        idle();
        cycle();
        bus.out_ready = 1'b0;
        push_r();
        cycle();
        cycle();
        idle();
        check("pre_reset_count", {16'd0, bus.count}, 32'd5);
        bus.out_ready = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_count", {16'd0, bus.count}, 32'd0);
        bus.out_ready = 1'b0;
        push_r();
        cycle();
        idle();
        check("rst_next_addr", bus.addr, 32'd0);
        cycle();

        // Simultaneous push and pop at occupancy 1.
        do_reset();
        bus.out_ready = 1'b0;
        push_r();
        cycle();
        bus.out_ready = 1'b1;
        drive(3'd4, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        cycle();
        idle();
        bus.out_ready = 1'b0;
        check("sim_valid", {31'd0, bus.out_valid}, 32'd1);
        check("sim_addr", bus.addr, 32'd4);
        check("sim_ready", {31'd0, bus.in_ready}, 32'd1);
        cycle();

        // Random traffic including illegal formats and occasional resets.
        for (int i = 0; i < 800; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.fmt       = 3'($urandom_range(0, 7));
            bus.opcode    = 7'($urandom);
            bus.rd        = 5'($urandom);
            bus.rs1       = 5'($urandom);
            bus.rs2       = 5'($urandom);
            bus.funct3    = 3'($urandom);
            bus.funct7    = 7'($urandom);
            bus.imm       = $urandom;
            reset         = ($urandom_range(0, 63) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
